rate_pulse_gen: RTL and testbench



---
 rtl/rate_pulse_gen.sv | 92 +++++++++
 tb/tb_rate_pulse_gen.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_pulse_gen.sv
// ============================================================================
//  Module   : rate_pulse_gen
//  Purpose  : Selectable-rate one-cycle enable pulse generator with single-step.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rate_pulse_gen #(
   parameter int CLK_HZ = 50000000,
   parameter int WIDTH  = 28
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       sel,
   input  logic             step,
   output logic             pulse,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] c_RELOAD_0 = '0;
   localparam logic [WIDTH-1:0] c_RELOAD_1 = WIDTH'(CLK_HZ - 1);
   localparam logic [WIDTH-1:0] c_RELOAD_2 = WIDTH'(2 * CLK_HZ - 1);
   localparam logic [WIDTH-1:0] c_RELOAD_4 = WIDTH'(4 * CLK_HZ - 1);
   localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             pulse_q, pulse_d;
   logic [1:0]       sel_q;
   logic             s1_q, s2_q, s3_q;

   logic [WIDTH-1:0] w_reload;
   logic             w_sel_chg;
   logic             w_step_edge;

   always_comb begin
      w_reload = c_RELOAD_0;
      case (sel)
         2'b00:   w_reload = c_RELOAD_0;
         2'b01:   w_reload = c_RELOAD_1;
         2'b10:   w_reload = c_RELOAD_2;
         default: w_reload = c_RELOAD_4;
      endcase
   end

   assign w_sel_chg   = (sel != sel_q);
   assign w_step_edge = s2_q & ~s3_q;

   // A sel change always reloads and suppresses the pulse; step edges only
   // count while the divider is held, so they are dropped in RUN.
   always_comb begin
      count_d = count_q;
      pulse_d = 1'b0;
      if (w_sel_chg) begin
         count_d = w_reload;
      end else if (enable) begin
         if (count_q == '0) begin
            pulse_d = 1'b1;
            count_d = w_reload;
         end else begin
            count_d = count_q - c_ONE;
         end
      end
      if (!enable && w_step_edge) begin
         pulse_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         pulse_q <= 1'b0;
         sel_q   <= 2'b00;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         pulse_q <= pulse_d;
         sel_q   <= sel;
         s1_q    <= step;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
      end
   end

   assign pulse = pulse_q;
   assign count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_rate_pulse_gen.sv
// ============================================================================
//  Module   : tb_rate_pulse_gen
//  Purpose  : Directed self-checking bench for rate_pulse_gen (CLK_HZ=4, WIDTH=5).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rate_pulse_gen;

   localparam int c_CLK_HZ = 4;
   localparam int c_WIDTH  = 5;

   logic               clk = 1'b0;
   logic               reset;
   logic               enable;
   logic [1:0]         sel;
   logic               step;
   logic               pulse;
   logic [c_WIDTH-1:0] count;

   int checks = 0;
   int errors = 0;

   rate_pulse_gen #(
      .CLK_HZ (c_CLK_HZ),
      .WIDTH  (c_WIDTH)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .sel    (sel),
      .step   (step),
      .pulse  (pulse),
      .count  (count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for a pulse (bounded), then returns cycles until the next one.
   task automatic measure_gap(output int gap);
      int n;
      n = 0;
      while (pulse !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      gap = 0;
      do begin
         tick();
         gap++;
      end while (pulse !== 1'b1 && gap < 100);
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; sel = 2'b01; step = 1'b0;
      #2;
      checks++;
      if (count !== 5'd0 || pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_init: count=%0d pulse=%b, required count=0 pulse=0", count, pulse);
      end
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (count !== 5'd3 || pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_reload: count=%0d pulse=%b, required count=3 pulse=0", count, pulse);
      end
      tick();
      checks++;
      if (count !== 5'd2) begin
         errors++;
         $display("FAIL reset_precount: count=%0d, required 2", count);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (count !== 5'd0 || pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: count=%0d pulse=%b, required count=0 pulse=0", count, pulse);
      end
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (count !== 5'd3 || pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_reload: count=%0d pulse=%b, required count=3 pulse=0", count, pulse);
      end
   endtask

   task automatic test_rate_01();
      logic [c_WIDTH-1:0] exp_cnt [8] = '{5'd2, 5'd1, 5'd0, 5'd3, 5'd2, 5'd1, 5'd0, 5'd3};
      logic               exp_pul [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (count !== exp_cnt[i] || pulse !== exp_pul[i]) begin
            errors++;
            $display("FAIL rate01_seq[%0d]: count=%0d pulse=%b, required count=%0d pulse=%b",
                     i, count, pulse, exp_cnt[i], exp_pul[i]);
         end
      end
   endtask

   task automatic test_rate_slow();
      int gap;
      sel = 2'b10;
      tick();
      checks++;
      if (count !== 5'd7 || pulse !== 1'b0) begin
         errors++;
         $display("FAIL rate10_reload: count=%0d pulse=%b, required count=7 pulse=0", count, pulse);
      end
      measure_gap(gap);
      checks++;
      if (gap !== 8) begin
         errors++;
         $display("FAIL rate10_period: got %0d, required 8", gap);
      end
      sel = 2'b11;
      tick();
      checks++;
      if (count !== 5'd15 || pulse !== 1'b0) begin
         errors++;
         $display("FAIL rate11_reload: count=%0d pulse=%b, required count=15 pulse=0", count, pulse);
      end
      measure_gap(gap);
      checks++;
      if (gap !== 16) begin
         errors++;
         $display("FAIL rate11_period: got %0d, required 16", gap);
      end
   endtask

   task automatic test_rate_00();
      sel = 2'b00;
      tick();
      checks++;
      if (pulse !== 1'b0 || count !== 5'd0) begin
         errors++;
         $display("FAIL rate00_change: pulse=%b count=%0d, required pulse=0 count=0", pulse, count);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (pulse !== 1'b1 || count !== 5'd0) begin
            errors++;
            $display("FAIL rate00_cont[%0d]: pulse=%b count=%0d, required pulse=1 count=0", i, pulse, count);
         end
      end
   endtask

   task automatic test_rate_change();
      sel = 2'b11;
      tick();
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (count !== 5'd9) begin
         errors++;
         $display("FAIL ratechg_pre: count=%0d, required 9", count);
      end
      sel = 2'b01;
      tick();
      checks++;
      if (count !== 5'd3 || pulse !== 1'b0) begin
         errors++;
         $display("FAIL ratechg_reload: count=%0d pulse=%b, required count=3 pulse=0", count, pulse);
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if (pulse !== (i == 4)) begin
            errors++;
            $display("FAIL ratechg_pulse[%0d]: pulse=%b, required %b", i, pulse, (i == 4));
         end
      end
   endtask

   task automatic test_collision();
      // count is 3 here; three edges bring it to 0
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (count !== 5'd0) begin
         errors++;
         $display("FAIL collision_pre: count=%0d, required 0", count);
      end
      sel = 2'b10;
      tick();
      checks++;
      if (pulse !== 1'b0 || count !== 5'd7) begin
         errors++;
         $display("FAIL collision: pulse=%b count=%0d, required pulse=0 count=7", pulse, count);
      end
   endtask

   task automatic test_hold_resume();
      int bad;
      sel = 2'b01;
      tick();
      tick();
      checks++;
      if (count !== 5'd2) begin
         errors++;
         $display("FAIL hold_pre: count=%0d, required 2", count);
      end
      enable = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (count !== 5'd2 || pulse !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL hold_frozen: %0d bad cycles, required 0 (count=%0d pulse=%b)", bad, count, pulse);
      end
      enable = 1'b1;
      tick();
      tick();
      checks++;
      if (count !== 5'd0 || pulse !== 1'b0) begin
         errors++;
         $display("FAIL resume_count: count=%0d pulse=%b, required count=0 pulse=0", count, pulse);
      end
      enable = 1'b0;
      tick();
      checks++;
      if (pulse !== 1'b0 || count !== 5'd0) begin
         errors++;
         $display("FAIL hold_at_zero: pulse=%b count=%0d, required pulse=0 count=0", pulse, count);
      end
      enable = 1'b1;
      tick();
      checks++;
      if (pulse !== 1'b1 || count !== 5'd3) begin
         errors++;
         $display("FAIL resume_pulse: pulse=%b count=%0d, required pulse=1 count=3", pulse, count);
      end
   endtask

   task automatic test_step_hold();
      int npulse;
      int first;
      logic [c_WIDTH-1:0] held;
      enable = 1'b0;
      step   = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      held = count;
      for (int rep = 0; rep < 2; rep++) begin
         step   = 1'b1;
         npulse = 0;
         first  = -1;
         for (int i = 1; i <= 20; i++) begin
            tick();
            if (pulse === 1'b1) begin
               npulse++;
               if (first < 0) first = i;
            end
         end
         checks++;
         if (npulse != 1 || first != 3) begin
            errors++;
            $display("FAIL step_hold[%0d]: pulses=%0d at edge %0d, required 1 at edge 3", rep, npulse, first);
         end
         step = 1'b0;
         for (int i = 0; i < 3; i++) tick();
      end
      checks++;
      if (count !== held) begin
         errors++;
         $display("FAIL step_hold_count: count=%0d, required %0d", count, held);
      end
   endtask

   task automatic test_step_run();
      int gap;
      int bad;
      enable = 1'b1;
      sel    = 2'b01;
      measure_gap(gap);
      step = 1'b1;
      bad  = 0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (pulse !== ((i % 4) == 0)) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL step_run: %0d off-schedule cycles, required 0", bad);
      end
      step = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rate_01();
      test_rate_slow();
      test_rate_00();
      test_rate_change();
      test_collision();
      test_hold_resume();
      test_step_hold();
      test_step_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
